instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 18 +
 rtl/instruction_fetch_if_id_reg.sv | 48 ++++
 rtl/instruction_fetch.sv | 113 +++++++++++
 tb/tb_instruction_fetch.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared CPU definitions for the fetch stage: datapath width, reset vector
// and the fetch FSM encoding.
package instruction_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  // Clears the byte-offset bits so a redirect always lands on a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline register: load-enable, flush (drops valid only) and
// synchronous reset to an all-zero empty entry.
module if_id_reg
  import instruction_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] next_pc,
  input  logic [XLEN-1:0] next_inst,
  input  logic [XLEN-1:0] next_pc_plus4,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] pc_plus4
);

  logic            valid_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] inst_r;
  logic [XLEN-1:0] pc_plus4_r;

  // Flush wins over load; payload fields are left untouched by a flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r    <= 1'b0;
      pc_r       <= 32'h0000_0000;
      inst_r     <= 32'h0000_0000;
      pc_plus4_r <= 32'h0000_0000;
    end else if (flush) begin
      valid_r    <= 1'b0;
    end else if (load) begin
      valid_r    <= 1'b1;
      pc_r       <= next_pc;
      inst_r     <= next_inst;
      pc_plus4_r <= next_pc_plus4;
    end else begin
      valid_r    <= valid_r;
    end
  end

  assign valid    = valid_r;
  assign pc       = pc_r;
  assign inst     = inst_r;
  assign pc_plus4 = pc_plus4_r;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, RUN/HALTED control, fetch counter and
// misaligned-redirect flag; the IF/ID register lives in if_id_reg.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              MEM_DEPTH = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_dout,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_inst,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic            is_halted,
  output logic            misalign_err,
  output logic [XLEN-1:0] fetch_count
);

  if (MEM_DEPTH < 1) begin : g_depth_check
    $error("instruction_fetch: MEM_DEPTH must be positive");
  end

  fetch_state_t    state_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] fetch_count_r;
  logic            misalign_err_r;
  logic            is_halted_r;
  logic [XLEN-1:0] pc_plus4_s;
  logic            load_s;
  logic            flush_s;

  assign pc_plus4_s = pc_r + 32'd4;

  // IF/ID control: halt or redirect flush the entry, otherwise load unless stalled.
  always_comb begin
    load_s  = 1'b0;
    flush_s = 1'b0;
    if (state_r == RUN) begin
      if (halt_req || redirect_valid) begin
        flush_s = 1'b1;
      end else if (!stall) begin
        load_s = 1'b1;
      end else begin
        load_s = 1'b0;
      end
    end else begin
      flush_s = 1'b0;
    end
  end

  // PC, fetch FSM, counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= RUN;
      pc_r           <= RESET_PC;
      fetch_count_r  <= 32'h0000_0000;
      misalign_err_r <= 1'b0;
      is_halted_r    <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (halt_req) begin
            state_r     <= HALTED;
            is_halted_r <= 1'b1;
          end else if (redirect_valid) begin
            pc_r <= word_align(redirect_pc);
            if (redirect_pc[1:0] != 2'b00) begin
              misalign_err_r <= 1'b1;
            end
          end else if (!stall) begin
            pc_r          <= pc_plus4_s;
            fetch_count_r <= fetch_count_r + 32'd1;
          end
        end
        HALTED: begin
          state_r     <= HALTED;
          is_halted_r <= 1'b1;
        end
        default: begin
          state_r     <= HALTED;
          is_halted_r <= 1'b1;
        end
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk           (clk),
    .reset         (reset),
    .load          (load_s),
    .flush         (flush_s),
    .next_pc       (pc_r),
    .next_inst     (imem_dout),
    .next_pc_plus4 (pc_plus4_s),
    .valid         (if_id_valid),
    .pc            (if_id_pc),
    .inst          (if_id_inst),
    .pc_plus4      (if_id_pc_plus4)
  );

  assign imem_addr    = pc_r;
  assign is_halted    = is_halted_r;
  assign misalign_err = misalign_err_r;
  assign fetch_count  = fetch_count_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a behavioural model predicts the
// post-edge state each cycle, queues it, and it is compared after the edge.
module tb_instruction_fetch;
  localparam int MEM_DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid, halt_req;
  logic [31:0] redirect_pc, imem_addr, imem_dout;
  logic        if_id_valid, is_halted, misalign_err;
  logic [31:0] if_id_pc, if_id_inst, if_id_pc_plus4, fetch_count;

  logic [31:0] mem [MEM_DEPTH];

  instruction_fetch #(.RESET_PC(32'h0000_0000), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt_req(halt_req), .imem_addr(imem_addr),
    .imem_dout(imem_dout), .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
    .if_id_inst(if_id_inst), .if_id_pc_plus4(if_id_pc_plus4),
    .is_halted(is_halted), .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;
  assign imem_dout = mem[imem_addr[11:2]];

  typedef struct {
    logic [31:0] addr;
    logic        valid;
    logic        chk_fields;
    logic [31:0] pc, inst, pc4;
    logic        halted, mis;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // reference model state
  logic [31:0] m_pc, m_ipc, m_inst, m_pc4, m_cnt;
  logic        m_halted, m_mis, m_v, m_fields;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic step(input logic rst, input logic st, input logic rv,
                      input logic [31:0] rpc, input logic hr);
    exp_t e;
    reset = rst; stall = st; redirect_valid = rv; redirect_pc = rpc; halt_req = hr;
    if (rst) begin
      m_pc = 32'h0; m_halted = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
      m_v = 1'b0; m_ipc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_fields = 1'b1;
    end else if (!m_halted) begin
      if (hr) begin
        m_halted = 1'b1; m_v = 1'b0; m_fields = 1'b0;
      end else if (rv) begin
        if (rpc[1:0] != 2'b00) m_mis = 1'b1;
        m_pc = rpc & 32'hFFFF_FFFC; m_v = 1'b0; m_fields = 1'b0;
      end else if (!st) begin
        m_v = 1'b1; m_fields = 1'b1; m_ipc = m_pc;
        m_inst = mem[m_pc[11:2]]; m_pc4 = m_pc + 32'd4;
        m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
      end
    end
    e.addr = m_pc; e.valid = m_v; e.chk_fields = m_fields; e.pc = m_ipc;
    e.inst = m_inst; e.pc4 = m_pc4; e.halted = m_halted; e.mis = m_mis; e.cnt = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq("imem_addr", imem_addr, e.addr);
      check_eq("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
      check_eq("is_halted", {31'd0, is_halted}, {31'd0, e.halted});
      check_eq("misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
      check_eq("fetch_count", fetch_count, e.cnt);
      if (e.chk_fields) begin
        check_eq("if_id_pc", if_id_pc, e.pc);
        check_eq("if_id_inst", if_id_inst, e.inst);
        check_eq("if_id_pc_plus4", if_id_pc_plus4, e.pc4);
      end
    end
  endtask

  task automatic advance();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = 32'hA500_0000 | i;
    mem[0] = 32'h0050_0093; mem[1] = 32'h00A0_0113;
    mem[2] = 32'h0020_81B3; mem[3] = 32'h0000_0073;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; halt_req = 1'b0;
    @(negedge clk);

    // straight-line fetch from reset
    do_reset();
    check_eq("rst_valid", {31'd0, if_id_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      advance();
      check_eq("seq_pc", if_id_pc, 32'(i * 4));
    end
    check_eq("seq_count", fetch_count, 32'd4);
    check_eq("seq_inst3", if_id_inst, 32'h0000_0073);

    // stall holds PC and IF/ID
    do_reset();
    advance(); advance();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      check_eq("stall_pc", if_id_pc, 32'h4);
      check_eq("stall_inst", if_id_inst, 32'h00A0_0113);
      check_eq("stall_addr", imem_addr, 32'h8);
    end

    // redirect beats stall
    step(1'b0, 1'b1, 1'b1, 32'h40, 1'b0);
    check_eq("redir_addr", imem_addr, 32'h40);
    advance();
    check_eq("redir_pc", if_id_pc, 32'h40);

    // misaligned redirect sticks until reset
    step(1'b0, 1'b0, 1'b1, 32'h42, 1'b0);
    check_eq("mis_addr", imem_addr, 32'h40);
    for (int i = 0; i < 5; i++) advance();
    check_eq("mis_sticky", {31'd0, misalign_err}, 32'd1);

    // random mix of stall and redirect
    for (int i = 0; i < 60; i++)
      step(1'b0, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 5) == 0),
           32'($urandom_range(0, 255)), 1'b0);

    // halt at PC=0xC, then frozen
    do_reset();
    advance(); advance(); advance();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'(i % 3 == 0), 1'(i % 2 == 0), 32'h80, 1'(i == 5));
    check_eq("halt_addr", imem_addr, 32'hC);
    check_eq("halt_flag", {31'd0, is_halted}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check_eq("halt_rst_addr", imem_addr, 32'h0);

    // PC wraps past 2^32
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    advance();
    check_eq("wrap_addr", imem_addr, 32'h0);
    check_eq("wrap_pc4", if_id_pc_plus4, 32'h0);
    check_eq("wrap_pc", if_id_pc, 32'hFFFF_FFFC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
